// File: rtl/riscv_pkg.sv
// Shared RV32I constants, ALU operation enum and the pure ALU/branch helpers
// used by the single-cycle core.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ROM_DEPTH = 4096;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt selects SUB for funct3=0 and SRA for funct3=5
  function automatic alu_op_e alu_sel(logic [2:0] f3, logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] alu(alu_op_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $signed(a) >>> b[4:0];
      ALU_OR:   return a | b;
      default:  return a & b;
    endcase
  endfunction

  function automatic logic branch_taken(logic [2:0] f3, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return $signed(a) < $signed(b);
      F3_BGE:  return $signed(a) >= $signed(b);
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/regs.sv
// 32 x 32 register file: two combinational read ports, one synchronous write
// port; x0 is hardwired to zero.
module regs
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);
  logic [XLEN-1:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
endmodule

// File: rtl/riscv.sv
// Single-cycle RV32I integer core: PC register, one decode/execute block and
// the register file. Memory, fence and system opcodes retire as NOPs.
module riscv
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);
  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_data, rs2_data, rd_data, next_pc, op_a, op_b, pc_plus4;
  logic            we, link;
  alu_op_e         alu_op;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  regs regs_inst (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (we),
    .rd_addr  (rd),
    .rd_data  (rd_data)
  );

  always_comb begin
    we      = 1'b0;
    link    = 1'b0;
    alu_op  = ALU_ADD;
    op_a    = rs1_data;
    op_b    = rs2_data;
    next_pc = pc_plus4;
    case (opcode)
      OPC_OP: begin
        we     = 1'b1;
        alu_op = alu_sel(f3, f7 == F7_ALT);
      end
      OPC_OP_IMM: begin
        we     = 1'b1;
        op_b   = imm_i;
        alu_op = alu_sel(f3, (f3 == F3_SR) && (f7 == F7_ALT));
      end
      OPC_LUI: begin
        we   = 1'b1;
        op_a = '0;
        op_b = imm_u;
      end
      OPC_AUIPC: begin
        we   = 1'b1;
        op_a = pc;
        op_b = imm_u;
      end
      OPC_BRANCH: begin
        if (branch_taken(f3, rs1_data, rs2_data)) next_pc = pc + imm_b;
      end
      OPC_JAL: begin
        we      = 1'b1;
        link    = 1'b1;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        we      = 1'b1;
        link    = 1'b1;
        next_pc = (rs1_data + imm_i) & ~32'd1;
      end
      default: ;
    endcase
    rd_data = link ? pc_plus4 : alu(alu_op, op_a, op_b);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else      pc <= next_pc;
  end
endmodule

// File: rtl/rom.sv
// Instruction ROM: word-addressed by pc[13:2], combinational read, contents
// loaded from outside (no reset, no write port).
module rom
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] data
);
  logic [XLEN-1:0] rom_mem [0:ROM_DEPTH-1];
  logic            unused_addr;

  // Upper and byte-offset bits are ignored, so fetch wraps modulo 16 KiB.
  assign unused_addr = ^{addr[31:14], addr[1:0]};
  assign data = rom_mem[addr[13:2]];
endmodule

// File: rtl/soc.sv
// Core plus instruction ROM; instance names are part of the visible hierarchy.
module soc
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst
);
  logic [XLEN-1:0] pc, inst;

  riscv riscv_inst (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .pc   (pc)
  );

  rom rom_inst (
    .addr (pc),
    .data (inst)
  );
endmodule

// File: rtl/riscv_soc.sv
// Simulation top: clock and active-low asynchronous reset into the SoC.
module riscv_soc (
  input  logic clk,
  input  logic rst
);
  soc soc_inst (
    .clk (clk),
    .rst (rst)
  );
endmodule

// File: tb/tb_riscv_soc.sv
// Bench for riscv_soc: directed programs plus a random program, each run in
// lockstep with an instruction-level model of RV32I.
module tb_riscv_soc;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [31:0] m_rom [0:4095];
  logic [31:0] m_regs [0:31];
  logic [31:0] m_pc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  riscv_soc dut (
    .clk (clk),
    .rst (rst)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_reg(input int i);
    return dut.soc_inst.riscv_inst.regs_inst.regs[i];
  endfunction

  function automatic logic [31:0] dut_pc();
    return dut.soc_inst.riscv_inst.pc;
  endfunction

  // ---------------- encoders ----------------
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endfunction

  function automatic void model_step();
    logic [31:0] w, a, b, res, npc, imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit          wr;
    w   = m_rom[m_pc[13:2]];
    rd  = w[11:7];
    f3  = w[14:12];
    a   = m_regs[w[19:15]];
    b   = m_regs[w[24:20]];
    npc = m_pc + 32'd4;
    res = 32'h0;
    wr  = 0;
    if (w[6:0] == 7'h13) b = {{20{w[31]}}, w[31:20]};
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      wr = 1;
      case (f3)
        3'd0: res = (w[6:0] == 7'h33 && w[30]) ? a - b : a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = w[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end else if (w[6:0] == 7'h37) begin
      wr = 1; res = {w[31:12], 12'h0};
    end else if (w[6:0] == 7'h17) begin
      wr = 1; res = m_pc + {w[31:12], 12'h0};
    end else if (w[6:0] == 7'h6f) begin
      imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      wr = 1; res = m_pc + 32'd4; npc = m_pc + imm;
    end else if (w[6:0] == 7'h67) begin
      imm = {{20{w[31]}}, w[31:20]};
      wr = 1; res = m_pc + 32'd4; npc = (a + imm) & 32'hFFFF_FFFE;
    end else if (w[6:0] == 7'h63) begin
      bit t;
      imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      case (f3)
        3'd0: t = (a == b);
        3'd1: t = (a != b);
        3'd4: t = ($signed(a) < $signed(b));
        3'd5: t = ($signed(a) >= $signed(b));
        3'd6: t = (a < b);
        3'd7: t = (a >= b);
        default: t = 0;
      endcase
      if (t) npc = m_pc + imm;
    end
    if (wr && rd != 5'd0) m_regs[rd] = res;
    m_pc = npc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_program(input logic [31:0] words[$]);
    for (int i = 0; i < 4096; i++) begin
      m_rom[i] = (i < words.size()) ? words[i] : NOP;
      dut.soc_inst.rom_inst.rom_mem[i] = m_rom[i];
    end
  endtask

  task automatic compare_state(input string tag);
    check({tag, "_pc"}, dut_pc(), m_pc);
    for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut_reg(i), m_regs[i]);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    compare_state("in_reset");
    repeat (3) @(negedge clk);
    compare_state("reset_held");
    rst = 1'b1;
  endtask

  task automatic step(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_state(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] alu_prog[$];
  logic [31:0] prog[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;

    alu_prog = '{i_t(12'd5, 5'd0, 3'd0, 5'd1, 7'h13), i_t(12'hFFD, 5'd0, 3'd0, 5'd2, 7'h13),
                 r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), r_t(7'h20, 5'd2, 5'd1, 3'd0, 5'd4),
                 r_t(7'h00, 5'd2, 5'd1, 3'd3, 5'd5), r_t(7'h20, 5'd0, 5'd2, 3'd5, 5'd6)};

    // Reset and ALU program
    load_program(alu_prog);
    reset_dut();
    step(1, "alu");
    check("first_commit_pc", dut_pc(), 32'h4);
    check("first_commit_x1", dut_reg(1), 32'd5);
    step(5, "alu");
    check("alu_x3", dut_reg(3), 32'd2);
    check("alu_x4", dut_reg(4), 32'd8);
    check("alu_x5", dut_reg(5), 32'd1);
    check("alu_x6", dut_reg(6), 32'hFFFF_FFFD);

    // x0 immutability
    prog = '{i_t(12'd9, 5'd0, 3'd0, 5'd1, 7'h13), i_t(12'd7, 5'd0, 3'd0, 5'd0, 7'h13),
             r_t(7'h00, 5'd0, 5'd0, 3'd0, 5'd1)};
    load_program(prog);
    reset_dut();
    step(3, "x0");
    check("x0_x1", dut_reg(1), 32'd0);
    check("x0_x0", dut_reg(0), 32'd0);

    // Control flow
    prog = '{i_t(12'd1, 5'd0, 3'd0, 5'd2, 7'h13), i_t(12'd2, 5'd0, 3'd0, 5'd3, 7'h13), NOP, NOP,
             j_t(21'd8, 5'd1), i_t(12'd99, 5'd0, 3'd0, 5'd5, 7'h13),
             b_t(13'd8, 5'd3, 5'd2, 3'd1), i_t(12'd55, 5'd0, 3'd0, 5'd6, 7'h13),
             b_t(13'd8, 5'd3, 5'd2, 3'd0), i_t(12'h021, 5'd0, 3'd0, 5'd1, 7'h13),
             i_t(12'd0, 5'd1, 3'd0, 5'd0, 7'h67)};
    load_program(prog);
    reset_dut();
    step(5, "cf");
    check("jal_link", dut_reg(1), 32'h14);
    check("jal_pc", dut_pc(), 32'h18);
    step(1, "cf");
    check("bne_taken_pc", dut_pc(), 32'h20);
    step(1, "cf");
    check("beq_fall_pc", dut_pc(), 32'h24);
    step(2, "cf");
    check("jalr_pc", dut_pc(), 32'h20);
    check("skip_x5", dut_reg(5), 32'd0);
    check("skip_x6", dut_reg(6), 32'd0);

    // Signature: pass path
    prog = '{i_t(12'd1, 5'd0, 3'd0, 5'd27, 7'h13), i_t(12'd1, 5'd0, 3'd0, 5'd26, 7'h13), j_t(21'd0, 5'd0)};
    load_program(prog);
    reset_dut();
    step(8, "sig_pass");
    check("pass_x26", dut_reg(26), 32'd1);
    check("pass_x27", dut_reg(27), 32'd1);
    check("pass_loop_pc", dut_pc(), 32'h8);

    // Signature: fail path
    prog = '{i_t(12'd7, 5'd0, 3'd0, 5'd3, 7'h13), i_t(12'd1, 5'd0, 3'd0, 5'd26, 7'h13), j_t(21'd0, 5'd0)};
    load_program(prog);
    reset_dut();
    step(6, "sig_fail");
    check("fail_x27", dut_reg(27), 32'd0);
    check("fail_x3", dut_reg(3), 32'd7);
    check("fail_x26", dut_reg(26), 32'd1);

    // Reset mid-run: asynchronous clear, then identical restart timing
    load_program(alu_prog);
    reset_dut();
    step(3, "pre_mid");
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    compare_state("async_clear");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(3, "restart");
    check("restart_x3", dut_reg(3), 32'd2);
    check("restart_x4", dut_reg(4), 32'd0);
    step(3, "restart");
    check("restart_x6", dut_reg(6), 32'hFFFF_FFFD);

    // Random program: forward-only control flow so it always runs off the end
    prog = {};
    for (int k = 1; k <= 8; k++) begin
      logic [31:0] r;
      r = $urandom;
      prog.push_back(u_t(r[31:12], 5'(k), 7'h37));
      prog.push_back(i_t(r[11:0], 5'(k), 3'd0, 5'(k), 7'h13));
    end
    for (int k = 0; k < 160; k++) begin
      logic [31:0] r;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic        alt;
      int          kind;
      r    = $urandom;
      rd   = 5'($urandom_range(0, 15));
      rs1  = 5'($urandom_range(0, 15));
      rs2  = 5'($urandom_range(0, 15));
      f3   = 3'($urandom_range(0, 7));
      alt  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2: prog.push_back(r_t((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00, rs2, rs1, f3, rd));
        3, 4: begin
          if (f3 == 3'd1)      prog.push_back(i_t({7'h00, r[4:0]}, rs1, f3, rd, 7'h13));
          else if (f3 == 3'd5) prog.push_back(i_t({alt ? 7'h20 : 7'h00, r[4:0]}, rs1, f3, rd, 7'h13));
          else                 prog.push_back(i_t(r[11:0], rs1, f3, rd, 7'h13));
        end
        5: prog.push_back(u_t(r[19:0], rd, alt ? 7'h37 : 7'h17));
        6: begin
          logic [2:0] bf [6];
          bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
          prog.push_back(b_t(13'(4 * $urandom_range(1, 4)), rs2, rs1, bf[$urandom_range(0, 5)]));
        end
        7: prog.push_back(j_t(21'(4 * $urandom_range(1, 4)), rd));
        8: begin
          prog.push_back(u_t(20'h0, 5'd31, 7'h17));
          prog.push_back(i_t(12'd13, 5'd31, 3'd0, rd, 7'h67));
          prog.push_back(i_t(12'd77, 5'd0, 3'd0, 5'd20, 7'h13));
        end
        default: begin
          logic [6:0] nf [5];
          nf = '{7'h03, 7'h23, 7'h0f, 7'h73, 7'h0b};
          prog.push_back({r[31:7], nf[$urandom_range(0, 4)]});
        end
      endcase
    end
    load_program(prog);
    reset_dut();
    step(prog.size() + 10, "rand");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
